// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - decode and sequence one R/I-type ALU operation over valid/ready handshakes
module alu_issue (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic [31:0] instr_i,
   input  logic [31:0] rs1_data_i,
   input  logic [31:0] rs2_data_i,
   output logic [31:0] data1_o,
   output logic [31:0] data2_o,
   output logic [2:0]  ALUCtrl_o,
   input  logic [31:0] alu_data_i,
   input  logic        alu_zero_i,
   output logic        valid_o,
   input  logic        ready_i,
   output logic [31:0] result_o,
   output logic        zero_o,
   output logic        illegal_o,
   output logic [15:0] op_cnt_o
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011;
   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLL = 3'b101;
   localparam logic [2:0] ALU_SRA = 3'b110;
   localparam logic [2:0] ALU_SRL = 3'b111;

   state_t      state_q, state_d;
   logic        accept;
   logic        dec_legal;
   logic [2:0]  dec_ctrl;
   logic [31:0] dec_data2;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic        unused_instr_bits;

   assign opcode = instr_i[6:0];
   assign funct3 = instr_i[14:12];
   assign funct7 = instr_i[31:25];
   assign unused_instr_bits = ^{instr_i[19:15], instr_i[11:7]};

   assign ready_o = (state_q == S_IDLE);
   assign valid_o = (state_q == S_RESP);
   assign accept  = valid_i && ready_o;

   always_comb begin
      dec_legal = 1'b0;
      dec_ctrl  = ALU_ADD;
      dec_data2 = rs2_data_i;
      if (opcode == OP_R) begin
         case (funct3)
            3'b000: begin
               dec_legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
               dec_ctrl  = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
            end
            3'b111: begin dec_legal = (funct7 == F7_ZERO); dec_ctrl = ALU_AND; end
            3'b110: begin dec_legal = (funct7 == F7_ZERO); dec_ctrl = ALU_OR;  end
            3'b100: begin dec_legal = (funct7 == F7_ZERO); dec_ctrl = ALU_XOR; end
            3'b001: begin dec_legal = (funct7 == F7_ZERO); dec_ctrl = ALU_SLL; end
            3'b101: begin
               dec_legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
               dec_ctrl  = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            end
            default: dec_legal = 1'b0;
         endcase
      end else if (opcode == OP_I) begin
         // Non-shift immediates are sign-extended; shifts take only the 5-bit shamt
         dec_data2 = {{20{instr_i[31]}}, instr_i[31:20]};
         case (funct3)
            3'b000: begin dec_legal = 1'b1; dec_ctrl = ALU_ADD; end
            3'b111: begin dec_legal = 1'b1; dec_ctrl = ALU_AND; end
            3'b110: begin dec_legal = 1'b1; dec_ctrl = ALU_OR;  end
            3'b100: begin dec_legal = 1'b1; dec_ctrl = ALU_XOR; end
            3'b001: begin
               dec_legal = (funct7 == F7_ZERO);
               dec_ctrl  = ALU_SLL;
               dec_data2 = {27'b0, instr_i[24:20]};
            end
            3'b101: begin
               dec_legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
               dec_ctrl  = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
               dec_data2 = {27'b0, instr_i[24:20]};
            end
            default: dec_legal = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = dec_legal ? S_EXEC : S_RESP;
         S_EXEC:  state_d = S_RESP;
         S_RESP:  if (ready_i) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         data1_o   <= '0;
         data2_o   <= '0;
         ALUCtrl_o <= ALU_ADD;
         result_o  <= '0;
         zero_o    <= 1'b0;
         illegal_o <= 1'b0;
         op_cnt_o  <= '0;
      end else if (state_q == S_IDLE && accept) begin
         if (dec_legal) begin
            data1_o   <= rs1_data_i;
            data2_o   <= dec_data2;
            ALUCtrl_o <= dec_ctrl;
         end else begin
            result_o  <= '0;
            zero_o    <= 1'b0;
            illegal_o <= 1'b1;
         end
      end else if (state_q == S_EXEC) begin
         result_o  <= alu_data_i;
         zero_o    <= alu_zero_i;
         illegal_o <= 1'b0;
         op_cnt_o  <= op_cnt_o + 16'd1;
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - randomized self-checking bench for alu_issue against an instruction-level model
module tb_alu_issue;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        valid_i;
   logic        ready_o;
   logic [31:0] instr_i;
   logic [31:0] rs1_data_i;
   logic [31:0] rs2_data_i;
   logic [31:0] data1_o;
   logic [31:0] data2_o;
   logic [2:0]  ALUCtrl_o;
   logic [31:0] alu_data_i;
   logic        alu_zero_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] result_o;
   logic        zero_o;
   logic        illegal_o;
   logic [15:0] op_cnt_o;

   int n_checks = 0;
   int n_pass   = 0;
   logic [15:0] exp_cnt = 16'd0;

   alu_issue dut (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
      .instr_i(instr_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
      .data1_o(data1_o), .data2_o(data2_o), .ALUCtrl_o(ALUCtrl_o),
      .alu_data_i(alu_data_i), .alu_zero_i(alu_zero_i),
      .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
      .zero_o(zero_o), .illegal_o(illegal_o), .op_cnt_o(op_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // Stand-in for the external combinational ALU
   always_comb begin
      case (ALUCtrl_o)
         3'b000:  alu_data_i = data1_o + data2_o;
         3'b001:  alu_data_i = data1_o - data2_o;
         3'b010:  alu_data_i = data1_o & data2_o;
         3'b011:  alu_data_i = data1_o | data2_o;
         3'b100:  alu_data_i = data1_o ^ data2_o;
         3'b101:  alu_data_i = data1_o << data2_o[4:0];
         3'b110:  alu_data_i = $unsigned($signed(data1_o) >>> data2_o[4:0]);
         default: alu_data_i = data1_o >> data2_o[4:0];
      endcase
      alu_zero_i = (alu_data_i == 32'd0);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Instruction-level reference: legality, operand b, ALU code and final result
   task automatic ref_model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] rs2,
                            output bit legal, output logic [31:0] b, output logic [2:0] code,
                            output logic [31:0] res);
      logic [6:0] op;
      logic [6:0] f7;
      logic [2:0] f3;
      bit is_r, is_i, shift, alt;
      op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
      is_r = (op == 7'h33); is_i = (op == 7'h13);
      shift = (f3 == 3'd1) || (f3 == 3'd5);
      alt = (f7 == 7'h20);
      legal = 0;
      if (is_r) legal = (f7 == 0 && f3 != 3'd2 && f3 != 3'd3) || (alt && (f3 == 3'd0 || f3 == 3'd5));
      if (is_i) legal = (!shift && f3 != 3'd2 && f3 != 3'd3) || (f3 == 3'd1 && f7 == 0) ||
                        (f3 == 3'd5 && (f7 == 0 || alt));
      if (is_r)       b = rs2;
      else if (shift) b = {27'd0, ins[24:20]};
      else            b = {{20{ins[31]}}, ins[31:20]};
      case (f3)
         3'd0: begin code = (is_r && alt) ? 3'd1 : 3'd0; res = (is_r && alt) ? a - b : a + b; end
         3'd1: begin code = 3'd5; res = a << b[4:0]; end
         3'd4: begin code = 3'd4; res = a ^ b; end
         3'd5: begin
            code = alt ? 3'd6 : 3'd7;
            res  = alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
         end
         3'd6: begin code = 3'd3; res = a | b; end
         default: begin code = 3'd2; res = a & b; end
      endcase
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, ".ready"},   {31'd0, ready_o},   32'd1);
      check({tag, ".valid"},   {31'd0, valid_o},   32'd0);
      check({tag, ".data1"},   data1_o,            32'd0);
      check({tag, ".data2"},   data2_o,            32'd0);
      check({tag, ".ctrl"},    {29'd0, ALUCtrl_o}, 32'd0);
      check({tag, ".result"},  result_o,           32'd0);
      check({tag, ".zero"},    {31'd0, zero_o},    32'd0);
      check({tag, ".illegal"}, {31'd0, illegal_o}, 32'd0);
      check({tag, ".op_cnt"},  {16'd0, op_cnt_o},  32'd0);
   endtask

   // One full transaction starting at a negedge in IDLE; returns at a negedge back in IDLE
   task automatic do_op(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] rs2,
                        input int hold);
      bit legal;
      logic [31:0] b, res, eres;
      logic [2:0] code;
      ref_model(ins, a, rs2, legal, b, code, res);
      eres = legal ? res : 32'd0;
      check("idle.ready", {31'd0, ready_o}, 32'd1);
      valid_i = 1'b1; instr_i = ins; rs1_data_i = a; rs2_data_i = rs2;
      @(posedge clk_i); @(negedge clk_i);
      valid_i = 1'b0; instr_i = $urandom; rs1_data_i = $urandom; rs2_data_i = $urandom;
      if (legal) begin
         check("exec.valid", {31'd0, valid_o}, 32'd0);
         check("exec.ready", {31'd0, ready_o}, 32'd0);
         check("exec.ctrl",  {29'd0, ALUCtrl_o}, {29'd0, code});
         check("exec.data1", data1_o, a);
         check("exec.data2", data2_o, b);
         @(posedge clk_i); @(negedge clk_i);
         exp_cnt = exp_cnt + 16'd1;
      end
      check("resp.valid",   {31'd0, valid_o},   32'd1);
      check("resp.result",  result_o,           eres);
      check("resp.zero",    {31'd0, zero_o},    {31'd0, legal && res == 32'd0});
      check("resp.illegal", {31'd0, illegal_o}, {31'd0, !legal});
      check("resp.op_cnt",  {16'd0, op_cnt_o},  {16'd0, exp_cnt});
      for (int k = 0; k < hold; k++) begin
         valid_i = 1'b1; instr_i = 32'h00000013;
         @(posedge clk_i); @(negedge clk_i);
         valid_i = 1'b0;
         check("hold.valid",  {31'd0, valid_o}, 32'd1);
         check("hold.ready",  {31'd0, ready_o}, 32'd0);
         check("hold.result", result_o, eres);
         check("hold.op_cnt", {16'd0, op_cnt_o}, {16'd0, exp_cnt});
      end
      ready_i = 1'b1;
      @(posedge clk_i); @(negedge clk_i);
      ready_i = 1'b0;
      check("done.valid", {31'd0, valid_o}, 32'd0);
      check("done.ready", {31'd0, ready_o}, 32'd1);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] ins;
      int pick;
      ins = $urandom;
      pick = $urandom_range(0, 9);
      if (pick < 4)       ins[6:0] = 7'h33;
      else if (pick < 8)  ins[6:0] = 7'h13;
      else if (pick == 8) ins[6:0] = 7'h03;
      case ($urandom_range(0, 3))
         0, 1:    ins[31:25] = 7'h00;
         2:       ins[31:25] = 7'h20;
         default: ;
      endcase
      return ins;
   endfunction

   initial begin
      logic [31:0] a, c;
      rst_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
      instr_i = '0; rs1_data_i = '0; rs2_data_i = '0;
      repeat (2) @(negedge clk_i);
      check_reset_state("reset");
      rst_i = 1'b1;
      @(negedge clk_i);

      do_op(32'hFFB00093, 32'h5, 32'h1234, 0);
      check("addi.result", result_o, 32'h0);
      check("addi.zero", {31'd0, zero_o}, 32'd1);
      do_op(32'h40000033, 32'h10, 32'h20, 1);
      check("sub.result", result_o, 32'hFFFFFFF0);
      do_op(32'h40005033, 32'h80000000, 32'h4, 0);
      check("sra.result", result_o, 32'hF8000000);
      do_op(32'h41F05013, 32'h80000000, 32'h0, 0);
      check("srai.result", result_o, 32'hFFFFFFFF);
      check("srai.data2", data2_o, 32'h1F);
      do_op(32'h00002003, 32'h1, 32'h2, 0);
      check("load.illegal", {31'd0, illegal_o}, 32'd1);
      do_op(32'h02000033, 32'h1, 32'h2, 0);   // add with funct7=1 is illegal

      for (int i = 0; i < 80; i++) begin
         a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom;
         c = ($urandom_range(0, 3) == 0) ? a : $urandom;
         do_op(rand_instr(), a, c, $urandom_range(0, 2));
      end

      // Backpressure in RESP, then asynchronous reset mid-response
      valid_i = 1'b1; instr_i = 32'h40005033; rs1_data_i = 32'h80000000; rs2_data_i = 32'h4;
      @(posedge clk_i); @(negedge clk_i);
      valid_i = 1'b0;
      @(posedge clk_i); @(negedge clk_i);
      exp_cnt = exp_cnt + 16'd1;
      for (int k = 0; k < 3; k++) begin
         valid_i = 1'b1; instr_i = 32'h00000033;
         @(posedge clk_i); @(negedge clk_i);
         valid_i = 1'b0;
         check("bp.valid",  {31'd0, valid_o}, 32'd1);
         check("bp.ready",  {31'd0, ready_o}, 32'd0);
         check("bp.result", result_o, 32'hF8000000);
         check("bp.op_cnt", {16'd0, op_cnt_o}, {16'd0, exp_cnt});
      end
      #2 rst_i = 1'b0;
      #1 check_reset_state("abort_resp");
      @(negedge clk_i);
      rst_i = 1'b1;
      exp_cnt = 16'd0;
      @(negedge clk_i);

      // Reset during EXEC must suppress the response and the count
      valid_i = 1'b1; instr_i = 32'h00000033; rs1_data_i = 32'h3; rs2_data_i = 32'h4;
      @(posedge clk_i); @(negedge clk_i);
      valid_i = 1'b0;
      rst_i = 1'b0;
      #1 check_reset_state("abort_exec");
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      do_op(32'h00000033, 32'h3, 32'h4, 0);
      check("post.result", result_o, 32'h7);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_issue.md
# alu_issue

Sequencing front-end that sits between instruction decode and the combinational ALU. It accepts one RISC-V R-type or I-type arithmetic/logic instruction with its operand values over a valid/ready handshake. It decodes the instruction into the 3-bit ALU control code, drives the ALU operands, and registers the ALU result and zero flag. It then returns them to the consumer over a second valid/ready handshake.

## Interface

Parameters:
- none

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset; one clock, reset is asynchronous and active-low
- valid_i  in  1  request valid
- ready_o  out  1  request accepted when valid_i && ready_o at a rising edge
- instr_i  in  32  RISC-V instruction word
- rs1_data_i  in  32  first source operand value
- rs2_data_i  in  32  second source operand value; ignored for I-type
- data1_o  out  32  ALU operand 1
- data2_o  out  32  ALU operand 2
- ALUCtrl_o  out  3  ALU operation code
- alu_data_i  in  32  ALU result
- alu_zero_i  in  1  ALU zero flag
- valid_o  out  1  response valid
- ready_i  in  1  response consumed when valid_o && ready_i at a rising edge
- result_o  out  32  registered result
- zero_o  out  1  registered zero flag
- illegal_o  out  1  response carries an undecodable instruction
- op_cnt_o  out  16  count of completed legal operations

## Operation

- ALU codes: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 sll, 110 sra, 111 srl.
- R-type (opcode 0110011):
  - funct3/funct7 {000/0000000} → add; {000/0100000} → sub.
  - {111/0} → and; {110/0} → or; {100/0} → xor.
  - {001/0} → sll; {101/0} → srl; {101/0100000} → sra.
  - data2_o = rs2_data_i.
- I-type (opcode 0010011):
  - addi 000, andi 111, ori 110, xori 100; data2_o = sign-extended instr_i[31:20].
  - slli {001, instr[31:25]=0}, srli {101, 0}, srai {101, 0100000}; data2_o = {27'b0, instr_i[24:20]}.
- data1_o = rs1_data_i, captured at accept.
- Every other opcode/funct combination is illegal. This includes funct7 values other than those listed.
- The FSM has three states:
  - IDLE: ready_o=1. On accept: legal → EXEC; illegal → RESP with illegal_o=1, result_o=0, zero_o=0.
  - EXEC: data1_o/data2_o/ALUCtrl_o are held stable for one cycle. At the closing edge, result_o←alu_data_i, zero_o←alu_zero_i, illegal_o←0, op_cnt_o←op_cnt_o+1 (wraps 0xFFFF→0x0000). Next state is RESP.
  - RESP: valid_o=1. result_o/zero_o/illegal_o are held. On ready_i → IDLE.
- ready_o is high only in IDLE, so valid_i is ignored in EXEC and RESP. There is no overlap or pipelining.
- data1_o, data2_o and ALUCtrl_o are registers. They keep their last values outside EXEC.
- rs1_data_i, rs2_data_i and instr_i matter only at the accept edge.

## Timing

- Reset (rst_i low, asynchronous) forces:
  - state IDLE.
  - ready_o=1, valid_o=0.
  - data1_o=0, data2_o=0, ALUCtrl_o=000.
  - result_o=0, zero_o=0, illegal_o=0, op_cnt_o=0.
- Reset asserted in any state aborts the operation immediately. No response is produced and op_cnt_o is not incremented.
- Legal request accepted at edge t:
  - EXEC runs between t and t+1.
  - valid_o rises after edge t+1.
  - Minimum accept-to-response latency is 2 edges.
- Illegal request accepted at edge t: valid_o rises after edge t (1 edge).
- Response consumed at edge r: ready_o is high after r. The earliest next accept is edge r+1.
- The ALU is assumed combinational. alu_data_i must settle within the EXEC cycle.
- valid_o, ready_o and illegal_o are functions of registered state only. They have no combinational path from valid_i or ready_i.

## Test plan

- Reset, then addi instr_i=0xFFB00093 with rs1=0x00000005. Required: ALUCtrl_o=000 and data2_o=0xFFFFFFFB during EXEC; valid_o after 2 edges; result_o=0, zero_o=1, illegal_o=0, op_cnt_o=1.
- sub instr_i=0x40000033 with rs1=0x10, rs2=0x20. Required: ALUCtrl_o=001; result_o=0xFFFFFFF0, zero_o=0.
- sra instr_i=0x40005033 with rs1=0x80000000, rs2=0x00000004. Required: result_o=0xF8000000.
- srai instr_i=0x41F05013 with rs1=0x80000000. Required: data2_o=0x1F, result_o=0xFFFFFFFF.
- Load opcode instr_i=0x00002003. Required: valid_o after 1 edge; illegal_o=1, result_o=0; op_cnt_o unchanged.
- Backpressure and reset:
  - Hold ready_i=0 for 3 cycles in RESP while pulsing valid_i. Required: valid_o and result_o held; ready_o=0; no second accept.
  - Then drop rst_i mid-RESP. Required: all outputs at reset values immediately.
